// File: rtl/disposition_unwrap.sv
// Receive side of the disposition path: classifies, filters and queues
// packed disposition words for the executor, with saturating statistics.
module disposition_unwrap #(
    parameter int                DISP_W    = 64,
    parameter int                DEPTH     = 4,
    parameter logic [DISP_W-1:0] NOP_VALUE = '0,
    parameter bit                DROP_NOP  = 1'b1,
    parameter int                CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DISP_W-1:0]          in_disp,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DISP_W-1:0]          out_disp,
    output logic                       out_opcode,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [CNT_W-1:0]           disp_cnt,
    output logic [CNT_W-1:0]           nop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

    logic [DISP_W:0]    mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [OCC_W-1:0]   occ;
    logic               nop;
    logic               push;
    logic               pop;
    logic               wr_en;
    logic [DISP_W:0]    head;

    assign nop      = (in_disp == NOP_VALUE);
    assign in_ready = !rst && !flush && (occ < FULL);
    assign push     = in_valid && in_ready;
    assign out_valid = (occ != '0);
    assign pop      = out_valid && out_ready && !flush;
    // A dropped no-op is still a handshake; it just never reaches storage.
    assign wr_en    = push && !(nop && DROP_NOP);

    assign head       = mem[rd_ptr];
    assign out_disp   = out_valid ? head[DISP_W-1:0] : '0;
    assign out_opcode = out_valid ? head[DISP_W] : 1'b0;
    assign occupancy  = occ;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {nop, in_disp};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (wr_en && !pop) begin
                occ <= occ + OCC_W'(1);
            end else if (!wr_en && pop) begin
                occ <= occ - OCC_W'(1);
            end
        end
    end

    // in_ready already excludes flush, so a flushed push never counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_cnt <= '0;
            nop_cnt  <= '0;
        end else if (push) begin
            if (nop) begin
                if (nop_cnt != '1) begin
                    nop_cnt <= nop_cnt + CNT_W'(1);
                end
            end else if (disp_cnt != '1) begin
                disp_cnt <= disp_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_disposition_unwrap.sv
// Self-checking bench: two instances (dropping and forwarding no-ops)
// driven in lockstep and compared against a queue-based reference model.
module tb_disposition_unwrap;

    localparam int W   = 64;
    localparam int D   = 4;
    localparam int CW  = 4;
    localparam int MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          out_ready;
    logic [W-1:0]  in_disp;

    logic          rdy [2];
    logic          ov  [2];
    logic          op  [2];
    logic [W-1:0]  od  [2];
    logic [2:0]    occ [2];
    logic [CW-1:0] dc  [2];
    logic [CW-1:0] nc  [2];

    logic [W:0]    mq [2][$];
    int            cd [2];
    int            cn [2];
    int            compared = 0;
    int            mism = 0;

    always #5 clk = ~clk;

    disposition_unwrap #(
        .DISP_W(W), .DEPTH(D), .DROP_NOP(1'b1), .CNT_W(CW)
    ) u_drop (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy[0]), .in_disp(in_disp),
        .out_valid(ov[0]), .out_ready(out_ready),
        .out_disp(od[0]), .out_opcode(op[0]),
        .occupancy(occ[0]), .disp_cnt(dc[0]), .nop_cnt(nc[0])
    );

    disposition_unwrap #(
        .DISP_W(W), .DEPTH(D), .DROP_NOP(1'b0), .CNT_W(CW)
    ) u_keep (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy[1]), .in_disp(in_disp),
        .out_valid(ov[1]), .out_ready(out_ready),
        .out_disp(od[1]), .out_opcode(op[1]),
        .occupancy(occ[1]), .disp_cnt(dc[1]), .nop_cnt(nc[1])
    );

    task automatic chk(input string tag, input logic [W:0] obs,
                       input logic [W:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out();
        for (int k = 0; k < 2; k++) begin
            int n = mq[k].size();
            chk($sformatf("occ%0d", k), (W+1)'(occ[k]), (W+1)'(n));
            chk($sformatf("out_valid%0d", k), (W+1)'(ov[k]), (W+1)'(n != 0));
            chk($sformatf("out_disp%0d", k), (W+1)'(od[k]),
                (n != 0) ? (W+1)'(mq[k][0][W-1:0]) : '0);
            chk($sformatf("out_opcode%0d", k), (W+1)'(op[k]),
                (n != 0) ? (W+1)'(mq[k][0][W]) : '0);
            chk($sformatf("disp_cnt%0d", k), (W+1)'(dc[k]), (W+1)'(cd[k]));
            chk($sformatf("nop_cnt%0d", k), (W+1)'(nc[k]), (W+1)'(cn[k]));
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mq[k].delete();
            cd[k] = 0;
            cn[k] = 0;
        end
    endtask

    task automatic cycle(input logic iv, input logic [W-1:0] d,
                         input logic ordy, input logic fl);
        bit push [2];
        bit pop  [2];
        bit r;
        in_valid  = iv;
        in_disp   = d;
        out_ready = ordy;
        flush     = fl;
        #1;
        for (int k = 0; k < 2; k++) begin
            r = !fl && (mq[k].size() < D);
            chk($sformatf("in_ready%0d", k), (W+1)'(rdy[k]), (W+1)'(r));
            push[k] = iv && r;
            pop[k]  = ordy && !fl && (mq[k].size() != 0);
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (fl) begin
                mq[k].delete();
            end else begin
                if (pop[k]) void'(mq[k].pop_front());
                if (push[k]) begin
                    if (d == '0) begin
                        if (cn[k] < MAX) cn[k]++;
                        if (k == 1) mq[k].push_back({1'b1, d});
                    end else begin
                        if (cd[k] < MAX) cd[k]++;
                        mq[k].push_back({1'b0, d});
                    end
                end
            end
        end
        #1;
        check_out();
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_disp = '0;
        model_reset();
        #12;
        check_out();
        chk("rst_ready0", (W+1)'(rdy[0]), '0);
        chk("rst_ready1", (W+1)'(rdy[1]), '0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Fill to full, stall a fifth word, then let one pop free a slot.
        cycle(1, 64'h11, 0, 0);
        cycle(1, 64'h22, 0, 0);
        cycle(1, 64'h33, 0, 0);
        cycle(1, 64'h44, 0, 0);
        chk("full_occ", (W+1)'(occ[0]), (W+1)'(4));
        chk("full_head", (W+1)'(od[0]), (W+1)'(64'h11));
        chk("full_dcnt", (W+1)'(dc[0]), (W+1)'(4));
        cycle(1, 64'h55, 0, 0);
        cycle(1, 64'h55, 1, 0);
        cycle(1, 64'h55, 0, 0);
        chk("late_occ", (W+1)'(occ[0]), (W+1)'(4));
        repeat (4) cycle(0, 64'h0, 1, 0);

        // No-op filtering vs forwarding.
        cycle(1, 64'hA, 1, 0);
        cycle(1, 64'h0, 1, 0);
        cycle(1, 64'hB, 1, 0);
        repeat (4) cycle(0, 64'h0, 1, 0);
        cycle(1, 64'h0, 0, 0);
        cycle(1, 64'h7, 0, 0);
        chk("keep_nop_op", (W+1)'(op[1]), (W+1)'(1));
        repeat (3) cycle(0, 64'h0, 1, 0);

        // Steady push+pop at occupancy 2 across pointer wrap.
        cycle(1, 64'h100, 0, 0);
        cycle(1, 64'h101, 0, 0);
        for (int i = 0; i < 10; i++) cycle(1, 64'h102 + 64'(i), 1, 0);
        chk("steady_occ", (W+1)'(occ[0]), (W+1)'(2));

        // Flush beats concurrent push and pop.
        cycle(1, 64'h200, 0, 0);
        chk("pre_flush_occ", (W+1)'(occ[0]), (W+1)'(3));
        cycle(1, 64'h201, 1, 1);
        chk("flush_occ", (W+1)'(occ[0]), '0);
        chk("flush_valid", (W+1)'(ov[0]), '0);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            logic [W-1:0] d;
            d = ($urandom_range(0, 3) == 0) ? '0 : {$urandom, $urandom};
            cycle($urandom_range(0, 3) != 0, d,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
        end

        // Saturation while draining.
        for (int i = 0; i < 20; i++) cycle(1, 64'h300 + 64'(i), 1, 0);
        chk("sat_dcnt", (W+1)'(dc[0]), (W+1)'(MAX));

        // Asynchronous reset in the middle of a burst.
        cycle(1, 64'h400, 0, 0);
        cycle(1, 64'h401, 0, 0);
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("arst_valid%0d", k), (W+1)'(ov[k]), '0);
            chk($sformatf("arst_occ%0d", k), (W+1)'(occ[k]), '0);
            chk($sformatf("arst_disp%0d", k), (W+1)'(od[k]), '0);
            chk($sformatf("arst_ready%0d", k), (W+1)'(rdy[k]), '0);
            chk($sformatf("arst_dcnt%0d", k), (W+1)'(dc[k]), '0);
            chk($sformatf("arst_ncnt%0d", k), (W+1)'(nc[k]), '0);
        end
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        cycle(1, 64'h500, 0, 0);
        cycle(1, 64'h0, 1, 0);
        cycle(0, 64'h0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mism);
        $finish;
    end

endmodule
